// File: rtl/ext_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ext_mem_bridge
// Purpose  : Queues single-word read/write requests and issues them to a
//            grant-based memory port, returning in-order read data upstream.
// Revision : 1.0 - initial release
// ============================================================================
module ext_mem_bridge #(
  parameter int          CMD_DEPTH = 4,
  parameter int          RD_MAX    = 4,
  parameter logic [31:0] OFF_FMI   = 32'h0020_0000,
  parameter logic [31:0] OFF_FMO   = 32'h0040_0000,
  parameter logic [31:0] OFF_KEX   = 32'h0060_0000,
  parameter logic [31:0] OFF_KPW   = 32'h01A0_0000,
  parameter logic [31:0] OFF_KDW   = 32'h02C0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request_extmem,
  input  logic        write_extmem,
  input  logic [31:0] addr_extmem,
  input  logic [31:0] w_data,
  output logic        ready_extmem,
  output logic        valid_extmem,
  output logic [31:0] data_extmem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [2:0]  err
);

  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam int OW = $clog2(RD_MAX) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(CMD_DEPTH);
  localparam logic [OW-1:0] RD_MAX_C = OW'(RD_MAX);
  localparam logic [PW-1:0] LAST_C   = PW'(CMD_DEPTH - 1);
  // A misordered region map makes every write suspect.
  localparam bit REGIONS_OK = (OFF_FMI < OFF_FMO) && (OFF_FMO < OFF_KEX) &&
                              (OFF_KEX < OFF_KPW) && (OFF_KPW < OFF_KDW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t state, state_nx;

  logic        fifo_we   [CMD_DEPTH];
  logic [31:0] fifo_addr [CMD_DEPTH];
  logic [31:0] fifo_data [CMD_DEPTH];

  logic [PW-1:0] wptr, rptr, wptr_nx, rptr_nx;
  logic [CW-1:0] count, count_nx;
  logic [OW-1:0] outst, outst_nx;
  logic          push, pop, grant_rd, rv_ok, wr_bad;
  logic          head_bypass, head_we;
  logic [31:0]   head_addr, head_data;

  assign ready_extmem = (count < DEPTH_C);
  assign push         = (request_extmem | write_extmem) & ready_extmem;
  assign pop          = mem_req & mem_gnt;
  assign grant_rd     = pop & ~mem_we;
  assign rv_ok        = mem_rvalid & (outst != '0);
  assign mem_req      = (state == ISSUE);
  assign wr_bad       = write_extmem &
                        (!REGIONS_OK || (addr_extmem < OFF_FMO) || (addr_extmem >= OFF_KEX));

  always_comb begin
    count_nx    = count + CW'(push) - CW'(pop);
    outst_nx    = outst + OW'(grant_rd) - OW'(rv_ok);
    wptr_nx     = (wptr == LAST_C) ? '0 : wptr + PW'(1);
    rptr_nx     = rptr;
    if (pop) begin
      rptr_nx = (rptr == LAST_C) ? '0 : rptr + PW'(1);
    end
    // The entry being pushed becomes the head when the FIFO drains this cycle.
    head_bypass = push & (count == CW'(pop));
    head_we     = head_bypass ? write_extmem : fifo_we[rptr_nx];
    head_addr   = head_bypass ? addr_extmem  : fifo_addr[rptr_nx];
    head_data   = head_bypass ? w_data       : fifo_data[rptr_nx];
  end

  // Next state is judged on the post-update queue and read budget, so a
  // read is never offered while the budget is exhausted.
  always_comb begin
    state_nx = IDLE;
    if (count_nx != '0) begin
      if (!head_we && (outst_nx == RD_MAX_C)) begin
        state_nx = STALL;
      end else begin
        state_nx = ISSUE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wptr]   <= write_extmem;
      fifo_addr[wptr] <= addr_extmem;
      fifo_data[wptr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      outst        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      valid_extmem <= 1'b0;
      data_extmem  <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      err          <= '0;
    end else begin
      if (push) begin
        wptr <= wptr_nx;
      end
      rptr         <= rptr_nx;
      count        <= count_nx;
      outst        <= outst_nx;
      mem_we       <= head_we;
      mem_addr     <= head_addr;
      mem_wdata    <= head_data;
      valid_extmem <= rv_ok;
      if (rv_ok) begin
        data_extmem <= mem_rdata;
      end
      if (valid_extmem) begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (pop && mem_we) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
      err <= err | {mem_rvalid & (outst == '0),
                    push & wr_bad,
                    (request_extmem | write_extmem) & ~ready_extmem};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_mem_bridge
// Purpose  : Self-checking bench for ext_mem_bridge with a memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_mem_bridge;

  localparam int          CMD_DEPTH = 4;
  localparam int          RD_MAX    = 4;
  localparam logic [31:0] OFF_FMI   = 32'h0020_0000;
  localparam logic [31:0] OFF_FMO   = 32'h0040_0000;
  localparam logic [31:0] OFF_KEX   = 32'h0060_0000;

  logic        clk, rst;
  logic        request_extmem, write_extmem;
  logic [31:0] addr_extmem, w_data;
  logic        ready_extmem, valid_extmem;
  logic [31:0] data_extmem;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] rd_cnt, wr_cnt;
  logic [2:0]  err;

  ext_mem_bridge #(.CMD_DEPTH(CMD_DEPTH), .RD_MAX(RD_MAX)) dut (
    .clk(clk), .rst(rst),
    .request_extmem(request_extmem), .write_extmem(write_extmem),
    .addr_extmem(addr_extmem), .w_data(w_data),
    .ready_extmem(ready_extmem), .valid_extmem(valid_extmem), .data_extmem(data_extmem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err(err)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } cmd_t;
  typedef struct { int due; logic [31:0] data; } ret_t;

  cmd_t        cmd_q[$];
  cmd_t        gnt_log[$];
  logic [31:0] rd_exp[$];
  ret_t        rq[$];

  int checks = 0, errors = 0, cyc = 0, gnt_rd = 0;
  int gnt_mode = 1, lat_min = 2, lat_max = 2;
  bit ret_unlimited = 1'b1;
  int ret_limit = 0, ret_taken = 0, last_due = 0;
  int spur_req = 0, spur_done = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: grants per gnt_mode, returns reads in order after a latency.
  always begin : mem_model
    ret_t r;
    int   lat;
    @(posedge clk);
    #2;
    mem_rvalid = 1'b0;
    if (!rst) rq.delete();
    if (spur_req != spur_done) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      spur_done  = spur_done + 1;
    end else if (rq.size() > 0 && rq[0].due <= cyc && (ret_unlimited || ret_taken < ret_limit)) begin
      r          = rq.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = r.data;
      ret_taken  = ret_taken + 1;
    end
    case (gnt_mode)
      0:       mem_gnt = 1'b0;
      1:       mem_gnt = 1'b1;
      default: mem_gnt = 1'($urandom_range(0, 1));
    endcase
    if (rst && mem_req && mem_gnt) begin
      gnt_log.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
      if (!mem_we) begin
        lat   = int'($urandom_range(lat_max, lat_min));
        r.due = cyc + lat;
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        r.data   = mem_word(mem_addr);
        rq.push_back(r);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    request_extmem = 1'b0;
    write_extmem   = 1'b0;
    addr_extmem    = '0;
    w_data         = '0;
    gnt_mode = 1; lat_min = 2; lat_max = 2; ret_unlimited = 1'b1;
    cmd_q.delete();
    rd_exp.delete();
    repeat (2) step();
    gnt_rd = gnt_log.size();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ready_extmem, mem_req, valid_extmem, err, rd_cnt, wr_cnt, data_extmem} !==
        {1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0})
      begin errors++; $display("FAIL reset_state got rdy=%0b req=%0b vld=%0b err=%0b rd=%0d wr=%0d data=%0h want 1 0 0 0 0 0 0",
                               ready_extmem, mem_req, valid_extmem, err, rd_cnt, wr_cnt, data_extmem); end
  endtask

  task automatic test_single_read();
    step();
    request_extmem = 1'b1; addr_extmem = 32'h0020_0005;
    step();
    request_extmem = 1'b0;
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0020_0005})
      begin errors++; $display("FAIL single_issue got req=%0b we=%0b addr=%0h want 1 0 200005", mem_req, mem_we, mem_addr); end
    for (int k = 2; k <= 3; k++) begin
      step();
      checks++;
      if (valid_extmem !== 1'b0) begin errors++; $display("FAIL single_early_valid cycle %0d got %0b want 0", k, valid_extmem); end
    end
    step();
    checks++;
    if ({valid_extmem, data_extmem} !== {1'b1, mem_word(32'h0020_0005)})
      begin errors++; $display("FAIL single_data got vld=%0b data=%0h want 1 %0h", valid_extmem, data_extmem, mem_word(32'h0020_0005)); end
    step();
    checks++;
    if ({valid_extmem, data_extmem, rd_cnt} !== {1'b0, mem_word(32'h0020_0005), 32'd1})
      begin errors++; $display("FAIL single_after got vld=%0b data=%0h rd_cnt=%0d want 0 %0h 1", valid_extmem, data_extmem, rd_cnt, mem_word(32'h0020_0005)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    do_reset();
    base = OFF_FMO + 32'h100;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i >= 1 && i <= 4) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, base + 32'(i - 1), mem_word(base + 32'(i - 1))})
          begin errors++; $display("FAIL b2b_issue cycle %0d got req=%0b we=%0b addr=%0h wdata=%0h want 1 1 %0h %0h",
                                   i, mem_req, mem_we, mem_addr, mem_wdata, base + 32'(i - 1), mem_word(base + 32'(i - 1))); end
      end
      if (i == 5) begin
        checks++;
        if ({mem_req, wr_cnt, err} !== {1'b0, 32'd4, 3'b000})
          begin errors++; $display("FAIL b2b_done got req=%0b wr_cnt=%0d err=%0b want 0 4 0", mem_req, wr_cnt, err); end
      end
      if (i < 4) begin
        write_extmem = 1'b1; addr_extmem = base + 32'(i); w_data = mem_word(base + 32'(i));
      end else begin
        write_extmem = 1'b0;
      end
    end
  endtask

  task automatic test_fifo_full();
    int got;
    logic [31:0] a;
    do_reset();
    gnt_mode = 0; lat_min = 1; lat_max = 1;
    a = OFF_FMI + 32'h40;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (ready_extmem !== (i < 4)) begin errors++; $display("FAIL full_ready pulse %0d got %0b want %0b", i, ready_extmem, (i < 4)); end
      request_extmem = 1'b1; addr_extmem = a + 32'(i);
    end
    step();
    request_extmem = 1'b0;
    checks++;
    if ({ready_extmem, err} !== {1'b0, 3'b001}) begin errors++; $display("FAIL full_drop got rdy=%0b err=%0b want 0 001", ready_extmem, err); end
    gnt_mode = 1;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid_extmem) begin
        checks++;
        if (data_extmem !== mem_word(a + 32'(got)))
          begin errors++; $display("FAIL full_order resp %0d got %0h want %0h", got, data_extmem, mem_word(a + 32'(got))); end
        got++;
      end
    end
    checks++;
    if (got != 4) begin errors++; $display("FAIL full_resp_count got %0d want 4", got); end
  endtask

  task automatic test_stall();
    int base_g, nv;
    do_reset();
    ret_unlimited = 1'b0; ret_limit = ret_taken; lat_min = 1; lat_max = 1;
    base_g = gnt_log.size();
    for (int i = 0; i < 5; i++) begin
      step();
      request_extmem = 1'b1; addr_extmem = OFF_FMI + 32'(i);
    end
    step();
    request_extmem = 1'b0;
    repeat (8) step();
    checks++;
    if ({mem_req, 32'(gnt_log.size() - base_g)} !== {1'b0, 32'd4})
      begin errors++; $display("FAIL stall_grants got req=%0b grants=%0d want 0 4", mem_req, gnt_log.size() - base_g); end
    ret_limit = ret_taken + 1;
    nv = 0;
    repeat (8) begin step(); if (valid_extmem) nv++; end
    checks++;
    if ({mem_req, 32'(gnt_log.size() - base_g), 32'(nv)} !== {1'b0, 32'd5, 32'd1})
      begin errors++; $display("FAIL stall_resume got req=%0b grants=%0d valids=%0d want 0 5 1", mem_req, gnt_log.size() - base_g, nv); end
  endtask

  task automatic test_writes();
    do_reset();
    step();
    write_extmem = 1'b1; addr_extmem = 32'h0040_0010; w_data = 32'hCAFE_0001;
    step();
    write_extmem = 1'b0;
    repeat (3) step();
    checks++;
    if ({wr_cnt, err} !== {32'd1, 3'b000}) begin errors++; $display("FAIL write_in_region got wr_cnt=%0d err=%0b want 1 000", wr_cnt, err); end
    write_extmem = 1'b1; addr_extmem = 32'h0060_0000; w_data = 32'hCAFE_0002;
    step();
    write_extmem = 1'b0;
    repeat (3) step();
    checks++;
    if ({wr_cnt, err} !== {32'd2, 3'b010}) begin errors++; $display("FAIL write_out_region got wr_cnt=%0d err=%0b want 2 010", wr_cnt, err); end
  endtask

  task automatic test_spurious();
    int nv;
    do_reset();
    spur_req = spur_req + 1;
    nv = 0;
    repeat (4) begin step(); if (valid_extmem) nv++; end
    checks++;
    if ({32'(nv), err, rd_cnt} !== {32'd0, 3'b100, 32'd0})
      begin errors++; $display("FAIL spurious got valids=%0d err=%0b rd_cnt=%0d want 0 100 0", nv, err, rd_cnt); end
  endtask

  task automatic test_reset_mid();
    int base_g;
    do_reset();
    gnt_mode = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      write_extmem = 1'b1; addr_extmem = OFF_FMO + 32'(i); w_data = 32'(i);
    end
    step();
    write_extmem = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL midrst_queued got req=%0b want 1", mem_req); end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_async got req=%0b want 0", mem_req); end
    repeat (2) step();
    base_g = gnt_log.size();
    rst = 1'b1; gnt_mode = 1;
    repeat (6) step();
    checks++;
    if ({mem_req, wr_cnt, 32'(gnt_log.size() - base_g)} !== {1'b0, 32'd0, 32'd0})
      begin errors++; $display("FAIL midrst_flush got req=%0b wr_cnt=%0d grants=%0d want 0 0 0", mem_req, wr_cnt, gnt_log.size() - base_g); end
    spur_req = spur_req + 1;
    repeat (3) step();
    checks++;
    if (err[2] !== 1'b1) begin errors++; $display("FAIL midrst_late_rvalid got err2=%0b want 1", err[2]); end
  endtask

  task automatic test_random();
    localparam int N = 1500;
    int occ, outst, nrd, nwr, sel;
    bit e0, e1;
    cmd_t c, e;
    logic [31:0] a, want;
    do_reset();
    gnt_mode = 2; lat_min = 1; lat_max = 5;
    occ = 0; outst = 0; nrd = 0; nwr = 0; e0 = 0; e1 = 0;
    for (int i = 0; i < N + 400; i++) begin
      step();
      request_extmem = 1'b0; write_extmem = 1'b0;
      if (i == N) gnt_mode = 1;
      if (valid_extmem) begin
        checks++;
        want = (rd_exp.size() > 0) ? rd_exp.pop_front() : 32'hxxxx_xxxx;
        if (data_extmem !== want) begin errors++; $display("FAIL rand_rdata got %0h want %0h", data_extmem, want); end
        nrd++; outst--;
      end
      while (gnt_rd < gnt_log.size()) begin
        c = gnt_log[gnt_rd];
        gnt_rd++;
        e = (cmd_q.size() > 0) ? cmd_q.pop_front() : '{we: 1'bx, addr: 'x, data: 'x};
        checks++;
        if (c.we !== e.we || c.addr !== e.addr || (c.we && c.data !== e.data))
          begin errors++; $display("FAIL rand_cmd got we=%0b addr=%0h data=%0h want we=%0b addr=%0h data=%0h",
                                   c.we, c.addr, c.data, e.we, e.addr, e.data); end
        occ--;
        if (c.we) nwr++; else outst++;
      end
      checks++;
      if (outst > RD_MAX || outst < 0) begin errors++; $display("FAIL rand_outstanding got %0d want 0..%0d", outst, RD_MAX); end
      checks++;
      if (ready_extmem !== (occ < CMD_DEPTH)) begin errors++; $display("FAIL rand_ready got %0b want %0b", ready_extmem, (occ < CMD_DEPTH)); end
      if (i >= N && cmd_q.size() == 0 && rd_exp.size() == 0) break;
      if (i < N) begin
        sel = int'($urandom_range(0, 9));
        case ($urandom_range(0, 4))
          0:       a = OFF_FMI + $urandom_range(0, 32'hFFF);
          1:       a = OFF_FMO + $urandom_range(0, 32'hFFF);
          2:       a = OFF_KEX + $urandom_range(0, 32'hFFF);
          3:       a = OFF_FMO - 32'd1;
          default: a = OFF_KEX - 32'd1;
        endcase
        if (sel < 7) begin
          addr_extmem = a; w_data = $urandom;
          request_extmem = (sel < 4);
          write_extmem   = (sel >= 4);
          if (occ < CMD_DEPTH) begin
            cmd_q.push_back('{we: (sel >= 4), addr: a, data: w_data});
            occ++;
            if (sel < 4) rd_exp.push_back(mem_word(a));
            else if (a < OFF_FMO || a >= OFF_KEX) e1 = 1'b1;
          end else begin
            e0 = 1'b1;
          end
        end
      end
    end
    checks++;
    if (cmd_q.size() != 0 || rd_exp.size() != 0)
      begin errors++; $display("FAIL rand_drain_timeout got cmds=%0d reads=%0d want 0 0", cmd_q.size(), rd_exp.size()); end
    repeat (2) step();
    checks++;
    if ({rd_cnt, wr_cnt, err} !== {32'(nrd), 32'(nwr), 1'b0, e1, e0})
      begin errors++; $display("FAIL rand_counters got rd=%0d wr=%0d err=%0b want %0d %0d %0b", rd_cnt, wr_cnt, err, nrd, nwr, {1'b0, e1, e0}); end
  endtask

  initial begin
    rst = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    request_extmem = 1'b0; write_extmem = 1'b0; addr_extmem = '0; w_data = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_fifo_full();
    test_stall();
    test_writes();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ext_mem_bridge.md
EXT_MEM_BRIDGE -- requirements
Module: ext_mem_bridge

Interface
REQ-001 Parameters: CMD_DEPTH, default 4, command FIFO entries; RD_MAX, default 4, maximum outstanding reads; OFF_FMI 2*2^20, OFF_FMO 4*2^20, OFF_KEX 6*2^20, OFF_KPW 26*2^20, OFF_KDW 44*2^20, word-address region bases.
REQ-002 clk  in  1  single clock; all logic is rising-edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 request_extmem  in  1  one-cycle read-request pulse from inverted_residual_block.
REQ-005 write_extmem  in  1  one-cycle write-request pulse; request_extmem and write_extmem are never both high.
REQ-006 addr_extmem  in  32  word address of the request.
REQ-007 w_data  in  32  write data.
REQ-008 ready_extmem  out  1  high when the command FIFO has room.
REQ-009 valid_extmem  out  1  one-cycle read-data strobe.
REQ-010 data_extmem  out  32  read data, valid when valid_extmem is high.
REQ-011 mem_req  out  1  memory command valid.
REQ-012 mem_we  out  1  memory command is a write.
REQ-013 mem_addr  out  32  memory address.
REQ-014 mem_wdata  out  32  memory write data.
REQ-015 mem_gnt  in  1  memory accepts the command in a cycle where mem_req and mem_gnt are both high.
REQ-016 mem_rvalid  in  1  memory read-data strobe; reads return in order.
REQ-017 mem_rdata  in  32  memory read data.
REQ-018 rd_cnt  out  32  count of reads returned upstream.
REQ-019 wr_cnt  out  32  count of writes accepted by memory.
REQ-020 err  out  3  sticky flags: [0] request dropped while ready_extmem low, [1] write outside the FMO region, [2] mem_rvalid with no outstanding read.

Function
REQ-021 A pulse with ready_extmem high pushes {we, addr, data} into the command FIFO in the same cycle; ready_extmem = (FIFO count < CMD_DEPTH), computed from registered state.
REQ-022 A pulse with ready_extmem low is discarded and sets err[0].
REQ-023 FSM states: IDLE (FIFO empty), ISSUE (head valid, mem_req high), STALL (head is a read and outstanding == RD_MAX).
REQ-024 Transitions: IDLE->ISSUE on FIFO non-empty. ISSUE->IDLE on a grant that empties the FIFO. ISSUE->STALL when the head is a read and outstanding == RD_MAX. STALL->ISSUE when outstanding < RD_MAX.
REQ-025 mem_req, mem_we, mem_addr and mem_wdata are driven registered from the FIFO head; mem_req stays high with stable fields until granted.
REQ-026 A push into an empty FIFO reaches mem_req no earlier than the next cycle; back-to-back grants pop one entry per cycle, giving a throughput of 1 command per cycle.
REQ-027 Outstanding-read counter (width clog2(RD_MAX)+1) increments on a read grant and decrements on mem_rvalid; on a simultaneous grant and rvalid it holds.
REQ-028 mem_rvalid with outstanding == 0 sets err[2]; the counter does not underflow and no upstream strobe is produced.
REQ-029 On each valid mem_rvalid: valid_extmem = 1 and data_extmem = mem_rdata on the next cycle; read-to-data latency = memory latency + 1 cycle.
REQ-030 data_extmem holds its last value when valid_extmem is low.
REQ-031 Region decode on push. A write with addr < OFF_FMO or addr >= OFF_KEX sets err[1] and is still forwarded.
REQ-032 rd_cnt increments on each valid_extmem; wr_cnt increments on each write grant. Both wrap modulo 2^32.
REQ-033 FIFO pointers wrap modulo CMD_DEPTH. A simultaneous push and pop when full is impossible because ready_extmem is low; a simultaneous push and pop otherwise keeps the count.

Reset
REQ-034 rst low asynchronously clears the FIFO, the outstanding counter, the FSM (to IDLE), mem_req, valid_extmem, data_extmem, rd_cnt, wr_cnt and err to 0; ready_extmem is 1 in the first cycle after release.
REQ-035 Reset mid-operation drops all queued and outstanding commands; a mem_rvalid arriving after release counts as unexpected and sets err[2].

Verification
REQ-036 Single read to 0x200005 with mem_gnt tied high and memory latency 2 -> mem_req in cycle 1; valid_extmem in cycle 4 with the data; rd_cnt=1.
REQ-037 Six back-to-back read pulses with mem_gnt low -> first four accepted; ready_extmem low from the cycle after the fourth push; pulses 5-6 set err[0]; release gnt -> four ordered responses.
REQ-038 RD_MAX=4 and memory never returns data -> four grants, FSM in STALL, mem_req low; one rvalid -> exactly one more grant.
REQ-039 Write to 0x400010 then write to 0x600000 -> wr_cnt=2; err[1] set only after the second write.
REQ-040 Spurious mem_rvalid after reset -> err[2]=1, valid_extmem stays 0.
REQ-041 rst asserted with three queued commands -> mem_req low immediately; no further grants after release.
